// File: rtl/register_bus_arbiter_if.sv
// rtl/register_bus_arbiter_if.sv - host handshake and peripheral register bus bundle
interface register_bus_arbiter_if;
    logic        host_req;
    logic        host_write;
    logic [6:0]  host_index;
    logic [15:0] host_write_value;
    logic        host_ack;
    logic        host_timeout;
    logic [15:0] host_read_value;
    logic [6:0]  bus_index;
    logic        bus_read;
    logic        bus_write;
    logic [15:0] bus_write_value;
    logic [15:0] bus_read_value;

    modport master (
        input  host_req, host_write, host_index, host_write_value, bus_read_value,
        output host_ack, host_timeout, host_read_value,
        output bus_index, bus_read, bus_write, bus_write_value
    );

    modport slave (
        output host_req, host_write, host_index, host_write_value, bus_read_value,
        input  host_ack, host_timeout, host_read_value,
        input  bus_index, bus_read, bus_write, bus_write_value
    );
endinterface

// File: rtl/register_bus_arbiter.sv
// rtl/register_bus_arbiter.sv - core-priority register bus arbiter with host req/ack and starvation timeout
module register_bus_arbiter #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            core_index,
    input  logic                  core_read,
    input  logic                  core_write,
    input  logic [15:0]           core_write_value,
    output logic [15:0]           core_read_value,
    register_bus_arbiter_if.master rb
);
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} state_t;

    state_t     state;
    logic [7:0] wait_count;
    logic       timed_out;
    logic       core_strobe;
    logic       host_grant;

    assign core_strobe     = core_read | core_write;
    // The host only touches the bus in a core-free ISSUE cycle, and never while reset is held.
    assign host_grant      = (state == ISSUE) && !core_strobe && !reset;
    assign core_read_value = rb.bus_read_value;

    always_comb begin
        rb.bus_index       = core_index;
        rb.bus_write_value = core_write_value;
        rb.bus_read        = core_read;
        rb.bus_write       = core_write;
        if (host_grant) begin
            rb.bus_index       = rb.host_index;
            rb.bus_write_value = rb.host_write_value;
            rb.bus_read        = !rb.host_write;
            rb.bus_write       = rb.host_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            wait_count         <= 8'd0;
            timed_out          <= 1'b0;
            rb.host_ack        <= 1'b0;
            rb.host_timeout    <= 1'b0;
            rb.host_read_value <= 16'h0000;
        end else begin
            rb.host_ack     <= 1'b0;
            rb.host_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (rb.host_req) begin
                        state      <= WAIT;
                        wait_count <= 8'd0;
                        timed_out  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!rb.host_req) begin
                        state <= IDLE;
                    end else if (!core_strobe) begin
                        state <= ISSUE;
                    end else if ((TIMEOUT_CYCLES != 8'd0) &&
                                 (wait_count == TIMEOUT_CYCLES - 8'd1)) begin
                        state     <= RESP;
                        timed_out <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                // A core strobe landing in ISSUE bounces back to WAIT without clearing the count.
                ISSUE: state <= core_strobe ? WAIT : RESP;
                RESP: begin
                    state           <= IDLE;
                    rb.host_ack     <= 1'b1;
                    rb.host_timeout <= timed_out;
                    if (!timed_out && !rb.host_write) begin
                        rb.host_read_value <= rb.bus_read_value;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_register_bus_arbiter.sv
// tb/tb_register_bus_arbiter.sv - directed and randomized checks against a cycle-pattern reference model
module tb_register_bus_arbiter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [6:0]  core_index;
    logic        core_read;
    logic        core_write;
    logic [15:0] core_write_value;
    logic [15:0] crv_a, crv_b;

    logic        req, hwr;
    logic [6:0]  hidx;
    logic [15:0] hwdata, brv;
    int          sel;

    register_bus_arbiter_if ifa ();
    register_bus_arbiter_if ifb ();

    assign ifa.host_req         = req && (sel == 0);
    assign ifb.host_req         = req && (sel == 1);
    assign ifa.host_write       = hwr;
    assign ifb.host_write       = hwr;
    assign ifa.host_index       = hidx;
    assign ifb.host_index       = hidx;
    assign ifa.host_write_value = hwdata;
    assign ifb.host_write_value = hwdata;
    assign ifa.bus_read_value   = brv;
    assign ifb.bus_read_value   = brv;

    register_bus_arbiter dut_a (
        .clk(clk), .reset(reset),
        .core_index(core_index), .core_read(core_read), .core_write(core_write),
        .core_write_value(core_write_value), .core_read_value(crv_a),
        .rb(ifa.master)
    );

    register_bus_arbiter #(.TIMEOUT_CYCLES(8'd4)) dut_b (
        .clk(clk), .reset(reset),
        .core_index(core_index), .core_read(core_read), .core_write(core_write),
        .core_write_value(core_write_value), .core_read_value(crv_b),
        .rb(ifb.master)
    );

    logic [24:0] o_bus;
    logic        o_ack, o_to;
    logic [15:0] o_hrv, o_crv;
    always_comb begin
        if (sel == 1) begin
            o_bus = {ifb.bus_index, ifb.bus_read, ifb.bus_write, ifb.bus_write_value};
            o_ack = ifb.host_ack;  o_to = ifb.host_timeout;
            o_hrv = ifb.host_read_value;  o_crv = crv_b;
        end else begin
            o_bus = {ifa.bus_index, ifa.bus_read, ifa.bus_write, ifa.bus_write_value};
            o_ack = ifa.host_ack;  o_to = ifa.host_timeout;
            o_hrv = ifa.host_read_value;  o_crv = crv_a;
        end
    end

    int          total = 0;
    int          bad = 0;
    bit          busy [64];
    int          abort_at;
    bit          force_core_read;
    bit          resp_fix;
    logic [15:0] resp_val;
    logic [15:0] exp_hrv [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_busy();
        for (int i = 0; i < 64; i++) busy[i] = 1'b0;
    endtask

    // Pattern index 0 is the first cycle after req is sampled. The host issues on the first
    // cycle that is idle and follows an idle cycle; a busy cycle not preceded by an idle one
    // is a starved wait cycle, and the T-th such cycle gives up. Ack lands two cycles later.
    task automatic run_txn(input int s, input logic w, input logic [6:0] ix, input logic [15:0] wd);
        int          tv, issue_k, to_j, cnt, ack_rel, last_idx;
        bit          timed, b, cw, prev_idle;
        logic [24:0] exp_bus;
        tv = (s == 1) ? 4 : 64;
        issue_k = -1; to_j = -1; cnt = 0;
        for (int i = 0; i < 64; i++) begin
            prev_idle = (i >= 1) && !busy[i-1];
            if (!busy[i] && prev_idle) begin issue_k = i; break; end
            if (busy[i] && !prev_idle) begin
                cnt++;
                if (cnt == tv) begin to_j = i; break; end
            end
        end
        timed   = (issue_k < 0);
        ack_rel = (timed ? to_j : issue_k) + 2;
        if (abort_at >= 0) begin
            issue_k = -1; ack_rel = -100; timed = 1'b0; last_idx = abort_at + 4;
        end else begin
            last_idx = ack_rel + 1;
        end
        sel = s; hwr = w; hidx = ix; hwdata = wd;
        for (int idx = -1; idx <= last_idx; idx++) begin
            @(posedge clk); #1;
            req = !((abort_at >= 0 && idx >= abort_at) || (abort_at < 0 && idx >= ack_rel));
            b  = (idx >= 0 && idx < 64) ? busy[idx] : 1'b0;
            cw = force_core_read ? 1'b0 : 1'($urandom_range(0, 1));
            core_read        = b & !cw;
            core_write       = b & cw;
            core_index       = 7'($urandom);
            core_write_value = 16'($urandom);
            brv = (resp_fix && issue_k >= 0 && idx == issue_k + 1) ? resp_val : 16'($urandom);
            @(negedge clk);
            if (b)                                 exp_bus = {core_index, core_read, core_write, core_write_value};
            else if (issue_k >= 0 && idx == issue_k) exp_bus = {ix, !w, w, wd};
            else                                   exp_bus = {core_index, 2'b00, core_write_value};
            check("bus", 64'(o_bus), 64'(exp_bus));
            check("ack_timeout", 64'({o_ack, o_to}), 64'({idx == ack_rel, (idx == ack_rel) && timed}));
            check("host_read_value", 64'(o_hrv), 64'(exp_hrv[s]));
            check("core_read_value", 64'(o_crv), 64'(brv));
            if (issue_k >= 0 && idx == issue_k + 1 && !w) exp_hrv[s] = brv;
        end
        abort_at = -1; force_core_read = 1'b0; resp_fix = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; hwr = 1'b0; hidx = 7'd0; hwdata = 16'd0; brv = 16'd0; sel = 0;
        core_index = 7'd0; core_read = 1'b0; core_write = 1'b0; core_write_value = 16'd0;
        abort_at = -1; force_core_read = 1'b0; resp_fix = 1'b0; resp_val = 16'd0;
        exp_hrv[0] = 16'd0; exp_hrv[1] = 16'd0;
        clear_busy();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", 64'({ifa.host_ack, ifa.host_timeout, ifa.host_read_value, ifa.bus_read, ifa.bus_write}), 64'd0);
        check("reset_b", 64'({ifb.host_ack, ifb.host_timeout, ifb.host_read_value, ifb.bus_read, ifb.bus_write}), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // host read with core idle, fixed read data
        clear_busy(); resp_fix = 1'b1; resp_val = 16'hBEEF;
        run_txn(0, 1'b0, 7'h05, 16'h0000);
        check("t1_hrv", 64'(ifa.host_read_value), 64'h0000_0000_0000_BEEF);

        // host write against five cycles of core writes
        clear_busy();
        for (int i = 0; i < 5; i++) busy[i] = 1'b1;
        run_txn(0, 1'b1, 7'h10, 16'h1234);

        // starvation timeout on the short-timeout instance
        clear_busy();
        for (int i = 0; i < 12; i++) busy[i] = 1'b1;
        run_txn(1, 1'b0, 7'h33, 16'h0000);

        // abort in WAIT, then a normal request
        clear_busy();
        for (int i = 0; i < 6; i++) busy[i] = 1'b1;
        abort_at = 3;
        run_txn(0, 1'b1, 7'h44, 16'hAAAA);
        clear_busy();
        run_txn(0, 1'b1, 7'h45, 16'h5555);

        // reset while in ISSUE
        sel = 0; hwr = 1'b0; hidx = 7'h22;
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("rst_issue_strobes", 64'({ifa.bus_read, ifa.bus_write}), 64'd0);
        @(posedge clk); #1 req = 1'b0; core_write = 1'b1; core_index = 7'h6A; core_write_value = 16'hC0DE;
        @(negedge clk);
        check("rst_core_pass", 64'(o_bus), 64'({7'h6A, 1'b0, 1'b1, 16'hC0DE}));
        check("rst_outputs", 64'({ifa.host_ack, ifa.host_timeout, ifa.host_read_value}), 64'd0);
        @(posedge clk); #1 reset = 1'b0; core_write = 1'b0;
        exp_hrv[0] = 16'd0; exp_hrv[1] = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", 64'({ifa.host_ack, ifa.host_timeout, ifa.host_read_value}), 64'd0);
            @(posedge clk); #1;
        end

        // core read in the RESP cycle of a host read
        clear_busy(); busy[2] = 1'b1; force_core_read = 1'b1;
        run_txn(0, 1'b0, 7'h07, 16'h0000);

        for (int t = 0; t < 24; t++) begin
            clear_busy();
            for (int i = 0; i < 24; i++) busy[i] = ($urandom_range(0, 99) < 55);
            run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
